// File: rtl/rf_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_ctrl_pkg
// Description : Shared constants and state type for the register-file
//               write-port controller.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_ctrl_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int ZERO_REG = 0;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage : rf_ctrl_pkg
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard
// Description : Pending-write scoreboard with two read ports for hazard lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard #(
    parameter int NUM_REGS = rf_ctrl_pkg::NUM_REGS,
    parameter int ADDR_W   = rf_ctrl_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_set_en,
    input  logic [ADDR_W-1:0] i_set_idx,
    input  logic              i_clr_en,
    input  logic [ADDR_W-1:0] i_clr_idx,
    input  logic [ADDR_W-1:0] i_src1,
    input  logic [ADDR_W-1:0] i_src2,
    output logic              o_busy1,
    output logic              o_busy2
);
    import rf_ctrl_pkg::*;

    localparam logic [ADDR_W-1:0] c_zero_idx = ADDR_W'(ZERO_REG);

    logic [NUM_REGS-1:0] r_busy;

    // Set is applied after clear so a same-index issue keeps the register busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            if (i_clr_en) begin
                r_busy[i_clr_idx] <= 1'b0;
            end
            if (i_set_en) begin
                r_busy[i_set_idx] <= 1'b1;
            end
        end
    end

    assign o_busy1 = r_busy[i_src1] & (i_src1 != c_zero_idx);
    assign o_busy2 = r_busy[i_src2] & (i_src2 != c_zero_idx);

endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/rf_wb_controller.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_controller
// Description : Register-file write-port controller: init sweep, write-back
//               vs. multi-cycle arbitration with starvation guard, hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_controller #(
    parameter int                  NUM_REGS   = rf_ctrl_pkg::NUM_REGS,
    parameter int                  ADDR_W     = rf_ctrl_pkg::ADDR_W,
    parameter int                  DATA_W     = rf_ctrl_pkg::DATA_W,
    parameter logic [DATA_W-1:0]   INIT_VAL   = '0,
    parameter int                  STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_dest,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_dest,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_dest,
    input  logic [ADDR_W-1:0] chk_src1,
    input  logic [ADDR_W-1:0] chk_src2,
    output logic              hazard,
    output logic              wb_stall,
    output logic              init_done,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_dest,
    output logic [DATA_W-1:0] rf_data
);
    import rf_ctrl_pkg::*;

    localparam int                 c_starve_w   = $clog2(STARVE_MAX + 1);
    localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_MAX);
    localparam logic [ADDR_W-1:0]  c_zero_idx   = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0]  c_last_idx   = ADDR_W'(NUM_REGS - 1);

    state_t                  r_state;
    logic [ADDR_W-1:0]       r_init_cnt;
    logic                    r_init_done;
    logic [c_starve_w-1:0]   r_starve_cnt;

    logic w_run;
    logic w_a_eff;
    logic w_b_nz;
    logic w_force_b;
    logic w_b_sel;
    logic w_b_grant;
    logic w_iss_set;
    logic w_busy1;
    logic w_busy2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= INIT;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    if (r_init_cnt == c_last_idx) begin
                        r_state     <= RUN;
                        r_init_done <= 1'b1;
                        r_init_cnt  <= '0;
                    end else begin
                        r_init_cnt  <= r_init_cnt + 1'b1;
                    end
                end
                RUN: begin
                    r_state     <= RUN;
                    r_init_done <= 1'b1;
                end
                default: begin
                    r_state     <= INIT;
                    r_init_cnt  <= '0;
                    r_init_done <= 1'b0;
                end
            endcase
        end
    end

    assign w_run     = (r_state == RUN);
    assign w_a_eff   = a_we & (a_dest != c_zero_idx);
    assign w_b_nz    = (b_dest != c_zero_idx);
    assign w_force_b = w_run & b_valid & (r_starve_cnt == c_starve_max);
    assign w_b_sel   = w_force_b | ~w_a_eff;
    assign w_b_grant = w_run & w_b_sel & b_valid;
    assign w_iss_set = w_run & iss_en & (iss_dest != c_zero_idx);

    assign b_ready   = w_run & w_b_sel;
    assign wb_stall  = w_force_b;
    assign init_done = r_init_done;

    // Counts consecutive cycles a presented B result loses to A.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (!w_run || !b_valid || w_b_grant) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != c_starve_max) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    always_comb begin
        rf_we   = 1'b0;
        rf_dest = c_zero_idx;
        rf_data = '0;
        if (!w_run) begin
            rf_we   = 1'b1;
            rf_dest = r_init_cnt;
            rf_data = INIT_VAL;
        end else if (w_b_sel) begin
            rf_we   = b_valid & w_b_nz;
            rf_dest = b_dest;
            rf_data = b_data;
        end else begin
            rf_we   = 1'b1;
            rf_dest = a_dest;
            rf_data = a_data;
        end
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .i_set_en  (w_iss_set),
        .i_set_idx (iss_dest),
        .i_clr_en  (w_b_grant),
        .i_clr_idx (b_dest),
        .i_src1    (chk_src1),
        .i_src2    (chk_src2),
        .o_busy1   (w_busy1),
        .o_busy2   (w_busy2)
    );

    // No bypass: a register being retired this cycle still reports busy.
    assign hazard = ~r_init_done | w_busy1 | w_busy2;

endmodule : rf_wb_controller
`default_nettype wire

// File: tb/tb_rf_wb_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wb_controller
// Description : Directed self-checking bench for rf_wb_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_we;
    logic [4:0]  a_dest;
    logic [31:0] a_data;
    logic        b_valid;
    logic [4:0]  b_dest;
    logic [31:0] b_data;
    logic        b_ready;
    logic        iss_en;
    logic [4:0]  iss_dest;
    logic [4:0]  chk_src1;
    logic [4:0]  chk_src2;
    logic        hazard;
    logic        wb_stall;
    logic        init_done;
    logic        rf_we;
    logic [4:0]  rf_dest;
    logic [31:0] rf_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rf_wb_controller dut (
        .clk       (clk),
        .rst       (rst),
        .a_we      (a_we),
        .a_dest    (a_dest),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_dest    (b_dest),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .iss_en    (iss_en),
        .iss_dest  (iss_dest),
        .chk_src1  (chk_src1),
        .chk_src2  (chk_src2),
        .hazard    (hazard),
        .wb_stall  (wb_stall),
        .init_done (init_done),
        .rf_we     (rf_we),
        .rf_dest   (rf_dest),
        .rf_data   (rf_data)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic set_a(input logic we, input logic [4:0] dst, input logic [31:0] dat);
        a_we = we; a_dest = dst; a_data = dat;
    endtask

    task automatic set_b(input logic vld, input logic [4:0] dst, input logic [31:0] dat);
        b_valid = vld; b_dest = dst; b_data = dat;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Inputs change at posedge+1; outputs are sampled at posedge+3.
    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1;
        set_a(1'b0, 5'd0, 32'h0);
        set_b(1'b0, 5'd0, 32'h0);
        iss_en = 1'b0; iss_dest = 5'd0;
        chk_src1 = 5'd0; chk_src2 = 5'd0;
        #1;
        check_val("rst_init_done", {31'b0, init_done}, 32'd0);
        check_val("rst_b_ready",   {31'b0, b_ready},   32'd0);
        check_val("rst_wb_stall",  {31'b0, wb_stall},  32'd0);
        check_val("rst_hazard",    {31'b0, hazard},    32'd1);
        next_cycle();
        next_cycle();
        rst = 1'b0;

        // Init sweep; run-mode inputs must be ignored throughout.
        set_a(1'b1, 5'd5, 32'hDEAD);
        set_b(1'b1, 5'd6, 32'hBEEF);
        iss_en = 1'b1; iss_dest = 5'd3;
        for (int i = 0; i < 32; i++) begin
            settle();
            check_val("init_we",   {31'b0, rf_we},   32'd1);
            check_val("init_dest", {27'b0, rf_dest}, i);
            check_val("init_data", rf_data,          32'd0);
            check_val("init_haz",  {31'b0, hazard},  32'd1);
            check_val("init_brdy", {31'b0, b_ready}, 32'd0);
            check_val("init_done0",{31'b0, init_done}, 32'd0);
            next_cycle();
        end

        set_a(1'b0, 5'd0, 32'h0);
        set_b(1'b0, 5'd0, 32'h0);
        iss_en = 1'b0;
        chk_src1 = 5'd3;
        settle();
        check_val("run_done",   {31'b0, init_done}, 32'd1);
        check_val("run_hazard", {31'b0, hazard},    32'd0);
        check_val("run_idle_we",{31'b0, rf_we},     32'd0);
        check_val("run_idle_br",{31'b0, b_ready},   32'd1);
        next_cycle();

        // A wins, then B goes through once A is idle.
        set_a(1'b1, 5'd5, 32'hAA);
        set_b(1'b1, 5'd6, 32'hBB);
        settle();
        check_val("a_pri_we",   {31'b0, rf_we},   32'd1);
        check_val("a_pri_dest", {27'b0, rf_dest}, 32'd5);
        check_val("a_pri_data", rf_data,          32'hAA);
        check_val("a_pri_brdy", {31'b0, b_ready}, 32'd0);
        next_cycle();
        set_a(1'b0, 5'd0, 32'h0);
        settle();
        check_val("b_after_brdy", {31'b0, b_ready}, 32'd1);
        check_val("b_after_dest", {27'b0, rf_dest}, 32'd6);
        check_val("b_after_data", rf_data,          32'hBB);
        check_val("b_after_we",   {31'b0, rf_we},   32'd1);
        next_cycle();
        set_b(1'b0, 5'd0, 32'h0);

        // Scoreboard hazard on issue, retire.
        iss_en = 1'b1; iss_dest = 5'd7; chk_src1 = 5'd7;
        settle();
        check_val("iss_same_cyc", {31'b0, hazard}, 32'd0);
        next_cycle();
        iss_en = 1'b0;
        settle();
        check_val("iss_haz_src1", {31'b0, hazard}, 32'd1);
        chk_src1 = 5'd0; chk_src2 = 5'd7;
        settle();
        check_val("iss_haz_src2", {31'b0, hazard}, 32'd1);
        next_cycle();
        chk_src1 = 5'd7; chk_src2 = 5'd0;
        set_b(1'b1, 5'd7, 32'h77);
        settle();
        check_val("ret_haz_hold", {31'b0, hazard},  32'd1);
        check_val("ret_brdy",     {31'b0, b_ready}, 32'd1);
        check_val("ret_dest",     {27'b0, rf_dest}, 32'd7);
        next_cycle();
        set_b(1'b0, 5'd0, 32'h0);
        settle();
        check_val("ret_haz_drop", {31'b0, hazard}, 32'd0);
        next_cycle();

        // Starvation: four losses, forced on the fifth, twice in a row.
        set_a(1'b1, 5'd4, 32'h11);
        set_b(1'b1, 5'd8, 32'h22);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                settle();
                check_val("starve_brdy",  {31'b0, b_ready},  32'd0);
                check_val("starve_stall", {31'b0, wb_stall}, 32'd0);
                check_val("starve_dest",  {27'b0, rf_dest},  32'd4);
                next_cycle();
            end
            settle();
            check_val("force_stall", {31'b0, wb_stall}, 32'd1);
            check_val("force_brdy",  {31'b0, b_ready},  32'd1);
            check_val("force_dest",  {27'b0, rf_dest},  32'd8);
            check_val("force_data",  rf_data,           32'h22);
            next_cycle();
        end
        set_b(1'b0, 5'd0, 32'h0);
        settle();
        check_val("post_force_stall", {31'b0, wb_stall}, 32'd0);
        check_val("post_force_dest",  {27'b0, rf_dest},  32'd4);
        next_cycle();

        // Writes to register 0 are suppressed.
        set_a(1'b1, 5'd0, 32'h33);
        set_b(1'b1, 5'd9, 32'h99);
        settle();
        check_val("a0_brdy", {31'b0, b_ready}, 32'd1);
        check_val("a0_we",   {31'b0, rf_we},   32'd1);
        check_val("a0_dest", {27'b0, rf_dest}, 32'd9);
        check_val("a0_data", rf_data,          32'h99);
        next_cycle();
        set_b(1'b0, 5'd0, 32'h0);
        settle();
        check_val("a0_only_we", {31'b0, rf_we}, 32'd0);
        next_cycle();
        set_a(1'b0, 5'd0, 32'h0);
        set_b(1'b1, 5'd0, 32'h55);
        settle();
        check_val("b0_brdy", {31'b0, b_ready}, 32'd1);
        check_val("b0_we",   {31'b0, rf_we},   32'd0);
        next_cycle();
        set_b(1'b0, 5'd0, 32'h0);

        // Same-cycle set and clear on one register: set wins.
        iss_en = 1'b1; iss_dest = 5'd10; chk_src1 = 5'd10;
        next_cycle();
        set_b(1'b1, 5'd10, 32'hA0);
        next_cycle();
        iss_en = 1'b0;
        set_b(1'b0, 5'd0, 32'h0);
        settle();
        check_val("setwin_haz", {31'b0, hazard}, 32'd1);
        next_cycle();
        set_b(1'b1, 5'd10, 32'hA1);
        next_cycle();
        set_b(1'b0, 5'd0, 32'h0);
        settle();
        check_val("setwin_clr", {31'b0, hazard}, 32'd0);
        next_cycle();

        // Asynchronous reset mid-run with a pending B and busy[3].
        iss_en = 1'b1; iss_dest = 5'd3; chk_src1 = 5'd3;
        next_cycle();
        iss_en = 1'b0;
        set_a(1'b1, 5'd12, 32'h44);
        set_b(1'b1, 5'd12, 32'h66);
        settle();
        check_val("pre_rst_haz",  {31'b0, hazard},  32'd1);
        check_val("pre_rst_brdy", {31'b0, b_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check_val("mid_rst_done", {31'b0, init_done}, 32'd0);
        check_val("mid_rst_brdy", {31'b0, b_ready},   32'd0);
        check_val("mid_rst_haz",  {31'b0, hazard},    32'd1);
        check_val("mid_rst_dest", {27'b0, rf_dest},   32'd0);
        next_cycle();
        rst = 1'b0;
        settle();
        check_val("reinit_dest0", {27'b0, rf_dest}, 32'd0);
        check_val("reinit_we",    {31'b0, rf_we},   32'd1);
        for (int i = 0; i < 32; i++) next_cycle();
        set_a(1'b0, 5'd0, 32'h0);
        set_b(1'b0, 5'd0, 32'h0);
        settle();
        check_val("reinit_done",   {31'b0, init_done}, 32'd1);
        check_val("reinit_busy3",  {31'b0, hazard},    32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rf_wb_controller
`default_nettype wire
